decode_ctrl_stage: RTL and testbench
====================================

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameter ALU_W, default 4, width of alu_control; legal values >= 4.
REQ-002 Parameter EXT_BRANCH, default 1; 1 = all six branch conditions decode; 0 = only beq/bne, other branch funct3 values are illegal.
REQ-003 Parameter CNT_W, default 8, width of illegal_cnt.
REQ-004 clk  input  1  stage clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 instr  input  32  instruction from the fetch/decode register.
REQ-007 in_valid  input  1  instr holds a real instruction.
REQ-008 stall  input  1  hold the current registered bundle.
REQ-009 flush  input  1  replace the registered bundle with a bubble.
REQ-010 valid  output  1  registered bundle holds a real instruction.
REQ-011 reg_write, mem_write, alu_sel, alu_a_pc, branch, jump, jalr_sel  output  1 each  registered control bits; alu_sel=1 selects immediate as ALU B; alu_a_pc=1 selects PC as ALU A.
REQ-012 imm_sel  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 result_sel  output  2  00 ALU, 01 memory, 10 PC+4.
REQ-014 br_cond  output  3  branch condition, equal to instr[14:12] for a legal branch, else 000.
REQ-015 alu_control  output  ALU_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB; upper bits zero-extended.
REQ-016 illegal  output  1  registered instruction was undecodable.
REQ-017 illegal_cnt  output  CNT_W  saturating count of illegal instructions accepted.

Function
REQ-018 Decode is combinational from instr; every output is registered, giving a latency of exactly 1 clk.
REQ-019 Per clk edge, priority: flush > stall > load; load captures the decoded bundle with valid=in_valid.
REQ-020 flush: valid=0 and all control outputs 0; illegal_cnt unchanged.
REQ-021 stall without flush: all outputs hold; the instruction on instr is not counted.
REQ-022 Loading with in_valid=0 produces a bubble identical to REQ-020.
REQ-023 lw 0000011 (funct3 010): reg_write, alu_sel, imm I, result 01, ADD.
REQ-024 sw 0100011 (funct3 010): mem_write, alu_sel, imm S, ADD.
REQ-025 Branch 1100011: branch, imm B, SUB, br_cond=funct3; funct3 010/011 are illegal.
REQ-026 jal 1101111: reg_write, jump, imm J, result 10.
REQ-027 jalr 1100111 (funct3 000): reg_write, jump, jalr_sel, alu_sel, imm I, result 10, ADD.
REQ-028 lui 0110111: reg_write, alu_sel, imm U, PASSB.
REQ-029 auipc 0010111: reg_write, alu_sel, alu_a_pc, imm U, ADD.
REQ-030 R-type 0110011 funct3 mapping: 000 ADD, or SUB when instr[30]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when instr[30]=1; 110 OR; 111 AND. reg_write set, alu_sel 0.
REQ-031 I-type 0010011 uses the REQ-030 mapping, except that funct3 000 is always ADD; alu_sel=1, imm I.
REQ-032 Any other opcode or funct3 is illegal: illegal=1 and reg_write, mem_write, branch and jump forced 0; valid follows in_valid.
REQ-033 illegal_cnt increments by 1 on a load with in_valid=1 and an illegal decode; it saturates at all-ones and never wraps.
REQ-034 flush and stall asserted together: flush wins.

Reset
REQ-035 Asserting rst immediately clears every output to 0, including valid, illegal and illegal_cnt, regardless of clk.
REQ-036 After rst deasserts, the first rising edge performs a normal load.

Verification
REQ-037 instr=0x00208033 (add), in_valid=1 -> next edge: reg_write=1, alu_control=0, alu_sel=0, valid=1.
REQ-038 instr=0x40208033 (sub), then 0x4020D013 (srai) -> alu_control=1, then alu_control=9 with alu_sel=1.
REQ-039 instr=0x0020C463 (blt): EXT_BRANCH=1 -> branch=1, br_cond=100; EXT_BRANCH=0 -> illegal=1, branch=0, illegal_cnt +1.
REQ-040 Load lw, then stall=1 for 3 cycles while instr changes -> outputs unchanged; then flush=1 together with stall=1 -> valid=0, all control 0.
REQ-041 CNT_W=2, feed 5 illegal instructions (0xFFFFFFFF) -> illegal_cnt = 1, 2, 3, 3, 3.
REQ-042 rst pulse asserted between clock edges mid-stream -> all outputs 0 without waiting for a clock edge; the first edge after release loads normally.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// Decode/control stage: combinational decode of a 32-bit RV32I-style
// instruction into a control bundle, registered with one cycle of latency.
// Supports stall (hold), flush (bubble) and a saturating illegal-instruction
// counter.
module decode_ctrl_stage #(
  parameter int ALU_W      = 4,
  parameter int EXT_BRANCH = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic             valid,
  output logic             reg_write,
  output logic             mem_write,
  output logic             alu_sel,
  output logic             alu_a_pc,
  output logic             branch,
  output logic             jump,
  output logic             jalr_sel,
  output logic [2:0]       imm_sel,
  output logic [1:0]       result_sel,
  output logic [2:0]       br_cond,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // One registered control bundle; a bubble is simply all zeros.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_sel;
    logic       alu_a_pc;
    logic       branch;
    logic       jump;
    logic       jalr_sel;
    logic [2:0] imm_sel;
    logic [1:0] result_sel;
    logic [2:0] br_cond;
    logic [3:0] alu;
    logic       illegal;
  } bundle_t;

  bundle_t    dec;
  bundle_t    bq;
  logic       bad;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       b30;
  logic       br_ok;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign b30    = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // beq/bne always decode; the four compare-style branches only when enabled.
  assign br_ok = (f3 == 3'b000) || (f3 == 3'b001) ||
                 ((EXT_BRANCH != 0) && f3[2]);

  // Shared R/I-type funct3 -> ALU op; only R-type uses bit 30 for SUB.
  function automatic logic [3:0] alu_op(input logic [2:0] fn, input logic alt,
                                        input logic is_r);
    case (fn)
      3'b000:  alu_op = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // Combinational decode; an illegal encoding collapses to illegal-only.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    bad       = 1'b0;
    case (opcode)
      7'b0000011: begin
        bad            = (f3 != 3'b010);
        dec.reg_write  = 1'b1;
        dec.alu_sel    = 1'b1;
        dec.result_sel = 2'b01;
      end
      7'b0100011: begin
        bad           = (f3 != 3'b010);
        dec.mem_write = 1'b1;
        dec.alu_sel   = 1'b1;
        dec.imm_sel   = 3'b001;
      end
      7'b1100011: begin
        bad         = !br_ok;
        dec.branch  = 1'b1;
        dec.imm_sel = 3'b010;
        dec.alu     = ALU_SUB;
        dec.br_cond = f3;
      end
      7'b1101111: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.imm_sel    = 3'b011;
        dec.result_sel = 2'b10;
      end
      7'b1100111: begin
        bad            = (f3 != 3'b000);
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.jalr_sel   = 1'b1;
        dec.alu_sel    = 1'b1;
        dec.result_sel = 2'b10;
      end
      7'b0110111: begin
        dec.reg_write = 1'b1;
        dec.alu_sel   = 1'b1;
        dec.imm_sel   = 3'b100;
        dec.alu       = ALU_PASSB;
      end
      7'b0010111: begin
        dec.reg_write = 1'b1;
        dec.alu_sel   = 1'b1;
        dec.alu_a_pc  = 1'b1;
        dec.imm_sel   = 3'b100;
      end
      7'b0110011: begin
        dec.reg_write = 1'b1;
        dec.alu       = alu_op(f3, b30, 1'b1);
      end
      7'b0010011: begin
        dec.reg_write = 1'b1;
        dec.alu_sel   = 1'b1;
        dec.alu       = alu_op(f3, b30, 1'b0);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end
  end

  // Bundle register: flush beats stall beats load; in_valid=0 loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           bq <= '0;
    else if (flush)    bq <= '0;
    else if (!stall)   bq <= in_valid ? dec : '0;
  end

  // Saturating count of illegal instructions actually accepted by a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= '0;
    else if (!flush && !stall && in_valid && dec.illegal && (illegal_cnt != '1))
      illegal_cnt <= illegal_cnt + CNT_W'(1);
  end

  assign valid       = bq.valid;
  assign reg_write   = bq.reg_write;
  assign mem_write   = bq.mem_write;
  assign alu_sel     = bq.alu_sel;
  assign alu_a_pc    = bq.alu_a_pc;
  assign branch      = bq.branch;
  assign jump        = bq.jump;
  assign jalr_sel    = bq.jalr_sel;
  assign imm_sel     = bq.imm_sel;
  assign result_sel  = bq.result_sel;
  assign br_cond     = bq.br_cond;
  assign alu_control = ALU_W'(bq.alu);
  assign illegal     = bq.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: two instances (extended branches / 8-bit
// counter, and beq/bne-only / 2-bit counter) share one stimulus stream and
// are compared each cycle against an instruction-level reference model.
module tb_decode_ctrl_stage;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_sel;
    logic       alu_a_pc;
    logic       branch;
    logic       jump;
    logic       jalr_sel;
    logic [2:0] imm_sel;
    logic [1:0] result_sel;
    logic [2:0] br_cond;
    logic [3:0] alu;
    logic       illegal;
  } ctl_t;

  // clock / reset / inputs
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  // instance A outputs
  logic a_valid, a_reg_write, a_mem_write, a_alu_sel, a_alu_a_pc, a_branch;
  logic a_jump, a_jalr_sel, a_illegal;
  logic [2:0] a_imm_sel, a_br_cond;
  logic [1:0] a_result_sel;
  logic [3:0] a_alu;
  logic [7:0] a_cnt;
  // instance B outputs
  logic b_valid, b_reg_write, b_mem_write, b_alu_sel, b_alu_a_pc, b_branch;
  logic b_jump, b_jalr_sel, b_illegal;
  logic [2:0] b_imm_sel, b_br_cond;
  logic [1:0] b_result_sel;
  logic [3:0] b_alu;
  logic [1:0] b_cnt;

  decode_ctrl_stage #(.ALU_W(4), .EXT_BRANCH(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .stall(stall),
    .flush(flush), .valid(a_valid), .reg_write(a_reg_write),
    .mem_write(a_mem_write), .alu_sel(a_alu_sel), .alu_a_pc(a_alu_a_pc),
    .branch(a_branch), .jump(a_jump), .jalr_sel(a_jalr_sel),
    .imm_sel(a_imm_sel), .result_sel(a_result_sel), .br_cond(a_br_cond),
    .alu_control(a_alu), .illegal(a_illegal), .illegal_cnt(a_cnt)
  );

  decode_ctrl_stage #(.ALU_W(4), .EXT_BRANCH(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .in_valid(in_valid), .stall(stall),
    .flush(flush), .valid(b_valid), .reg_write(b_reg_write),
    .mem_write(b_mem_write), .alu_sel(b_alu_sel), .alu_a_pc(b_alu_a_pc),
    .branch(b_branch), .jump(b_jump), .jalr_sel(b_jalr_sel),
    .imm_sel(b_imm_sel), .result_sel(b_result_sel), .br_cond(b_br_cond),
    .alu_control(b_alu), .illegal(b_illegal), .illegal_cnt(b_cnt)
  );

  ctl_t got_a, got_b;
  assign got_a = {a_valid, a_reg_write, a_mem_write, a_alu_sel, a_alu_a_pc,
                  a_branch, a_jump, a_jalr_sel, a_imm_sel, a_result_sel,
                  a_br_cond, a_alu, a_illegal};
  assign got_b = {b_valid, b_reg_write, b_mem_write, b_alu_sel, b_alu_a_pc,
                  b_branch, b_jump, b_jalr_sel, b_imm_sel, b_result_sel,
                  b_br_cond, b_alu, b_illegal};

  // scoreboard state
  int   checks = 0;
  int   failures = 0;
  ctl_t exp_a = '0;
  ctl_t exp_b = '0;
  int   cnt_a = 0;
  int   cnt_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what each instruction means, table style.
  function automatic ctl_t model(input logic [31:0] ins, input bit ext);
    ctl_t       c;
    logic [2:0] fn;
    bit         ok;
    logic [3:0] r_map [8];
    r_map = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    fn = ins[14:12];
    ok = 1;
    c = '0;
    c.valid = 1'b1;
    case (ins[6:0])
      7'h03: begin ok = (fn == 3'd2); c.reg_write = 1; c.alu_sel = 1; c.result_sel = 2'd1; end
      7'h23: begin ok = (fn == 3'd2); c.mem_write = 1; c.alu_sel = 1; c.imm_sel = 3'd1; end
      7'h63: begin
        ok = ext ? (fn != 3'd2 && fn != 3'd3) : (fn < 3'd2);
        c.branch = 1; c.imm_sel = 3'd2; c.alu = 4'd1; c.br_cond = fn;
      end
      7'h6F: begin c.reg_write = 1; c.jump = 1; c.imm_sel = 3'd3; c.result_sel = 2'd2; end
      7'h67: begin
        ok = (fn == 3'd0);
        c.reg_write = 1; c.jump = 1; c.jalr_sel = 1; c.alu_sel = 1; c.result_sel = 2'd2;
      end
      7'h37: begin c.reg_write = 1; c.alu_sel = 1; c.imm_sel = 3'd4; c.alu = 4'd10; end
      7'h17: begin c.reg_write = 1; c.alu_sel = 1; c.alu_a_pc = 1; c.imm_sel = 3'd4; end
      7'h33: begin
        c.reg_write = 1; c.alu = r_map[fn];
        if (ins[30] && fn == 3'd0) c.alu = 4'd1;
        if (ins[30] && fn == 3'd5) c.alu = 4'd9;
      end
      7'h13: begin
        c.reg_write = 1; c.alu_sel = 1; c.alu = r_map[fn];
        if (ins[30] && fn == 3'd5) c.alu = 4'd9;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      c = '0;
      c.valid = 1'b1;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, "_bundle_a"}, 32'(got_a), 32'(exp_a));
    chk({tag, "_bundle_b"}, 32'(got_b), 32'(exp_b));
    chk({tag, "_cnt_a"}, 32'(a_cnt), 32'(cnt_a));
    chk({tag, "_cnt_b"}, 32'(b_cnt), 32'(cnt_b));
  endtask

  // driver: one clock of stimulus, model update, then check after the edge
  task automatic step(input logic [31:0] ins, input logic iv, input logic st,
                      input logic fl, input string tag);
    ctl_t ma, mb;
    @(negedge clk);
    instr = ins; in_valid = iv; stall = st; flush = fl;
    ma = model(ins, 1);
    mb = model(ins, 0);
    if (fl) begin
      exp_a = '0; exp_b = '0;
    end else if (!st) begin
      if (iv) begin
        exp_a = ma; exp_b = mb;
        if (ma.illegal && cnt_a < 255) cnt_a++;
        if (mb.illegal && cnt_b < 3) cnt_b++;
      end else begin
        exp_a = '0; exp_b = '0;
      end
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // reset pulse between edges, then a normal first load after release
  task automatic pulse_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    exp_a = '0; exp_b = '0; cnt_a = 0; cnt_b = 0;
    #1 compare_all("async_rst");
    instr = 32'h00208033; in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    #1 rst = 1'b0;
    exp_a = model(32'h00208033, 1);
    exp_b = model(32'h00208033, 0);
    @(posedge clk);
    #1 compare_all("post_rst_load");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33, 7'h13, 7'h7F};
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  initial begin
    logic [1:0] sat_seq [5];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    #3 compare_all("reset");
    @(negedge clk) rst = 1'b0;

    step(32'h00208033, 1, 0, 0, "add");
    chk("add_reg_write", 32'(a_reg_write), 32'd1);
    chk("add_alu", 32'(a_alu), 32'd0);
    chk("add_alu_sel", 32'(a_alu_sel), 32'd0);
    chk("add_valid", 32'(a_valid), 32'd1);

    step(32'h40208033, 1, 0, 0, "sub");
    chk("sub_alu", 32'(a_alu), 32'd1);
    step(32'h4020D013, 1, 0, 0, "srai");
    chk("srai_alu", 32'(a_alu), 32'd9);
    chk("srai_alu_sel", 32'(a_alu_sel), 32'd1);

    step(32'h0020C463, 1, 0, 0, "blt");
    chk("blt_a_branch", 32'(a_branch), 32'd1);
    chk("blt_a_br_cond", 32'(a_br_cond), 32'd4);
    chk("blt_b_illegal", 32'(b_illegal), 32'd1);
    chk("blt_b_branch", 32'(b_branch), 32'd0);
    chk("blt_b_cnt", 32'(b_cnt), 32'd1);

    step(32'h0020A183, 1, 0, 0, "lw");
    for (int i = 0; i < 3; i++) step(rand_instr(), 1, 1, 0, "stall");
    chk("stall_hold_lw", 32'(got_a), 32'(model(32'h0020A183, 1)));
    step(32'hFFFFFFFF, 1, 1, 1, "flush_stall");
    chk("flush_valid", 32'(a_valid), 32'd0);

    pulse_rst();
    for (int i = 0; i < 5; i++) begin
      step(32'hFFFFFFFF, 1, 0, 0, "sat");
      chk("sat_cnt_b", 32'(b_cnt), 32'(sat_seq[i]));
    end

    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) pulse_rst();
      step(rand_instr(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
